// File: rtl/logic_unit_pkg.sv
// Shared constants for the shared bitwise logic unit and its two-port arbiter.
package logic_unit_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_OPW   = 2;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_ANDN = 2'b11
    } op_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/logic_unit_alu.sv
// Purely combinational WIDTH-bit bitwise unit: AND, OR, XOR and AND-NOT.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_ANDN: o_result = i_a & ~i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin sharing of one logic unit between two valid/ready requesters,
// with a single registered response slot and a saturating stall counter.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int OPW   = DEFAULT_OPW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic [15:0]      busy_cycles
);

    logic             r_resp_valid;
    logic             r_resp_id;
    logic [WIDTH-1:0] r_resp_result;
    logic [15:0]      r_busy_cycles;
    logic             r_last_grant;

    logic             w_slot_free;
    logic             w_grant_valid;
    logic             w_grant_id;
    logic             w_accept;
    logic [OPW-1:0]   w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;

    assign w_slot_free = !r_resp_valid || resp_ready;

    // On a tie the requester that did not win the last accept goes next.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = REQ0;
        if (req0_valid && req1_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = ~r_last_grant;
        end else if (req0_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = REQ0;
        end else if (req1_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = REQ1;
        end
    end

    assign req0_ready = w_slot_free && w_grant_valid && (w_grant_id == REQ0);
    assign req1_ready = w_slot_free && w_grant_valid && (w_grant_id == REQ1);
    assign w_accept   = w_slot_free && w_grant_valid;

    assign w_op = (w_grant_id == REQ1) ? req1_op : req0_op;
    assign w_a  = (w_grant_id == REQ1) ? req1_a  : req0_a;
    assign w_b  = (w_grant_id == REQ1) ? req1_b  : req0_b;

    logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic_unit (
        .i_op     (w_op[1:0]),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_result (w_result)
    );

    // A new accept overwrites the slot even while it is being drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_valid  <= 1'b0;
            r_resp_id     <= REQ0;
            r_resp_result <= '0;
            r_last_grant  <= REQ1;
        end else if (w_accept) begin
            r_resp_valid  <= 1'b1;
            r_resp_id     <= w_grant_id;
            r_resp_result <= w_result;
            r_last_grant  <= w_grant_id;
        end else if (r_resp_valid && resp_ready) begin
            r_resp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy_cycles <= '0;
        end else if (r_resp_valid && !resp_ready && (r_busy_cycles != 16'hFFFF)) begin
            r_busy_cycles <= r_busy_cycles + 16'd1;
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign busy_cycles = r_busy_cycles;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level reference model of the shared logic unit arbiter.
module tb_logic_unit_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id;
    logic [63:0] resp_result;
    logic [15:0] busy_cycles;

    int testsRun;
    int testsFailed;

    // Reference model: what the consumer should see in the response slot.
    bit          mValid;
    int          mId;
    logic [63:0] mResult;
    int          mBusy;
    int          mLastWinner;

    logic_unit_arbiter #(.WIDTH(64), .OPW(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op     (req0_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op     (req1_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .busy_cycles (busy_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] refOp(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return a & ~b;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit v0, input logic [1:0] op0, input logic [63:0] a0,
                                 input logic [63:0] b0, input bit v1, input logic [1:0] op1,
                                 input logic [63:0] a1, input logic [63:0] b1, input bit rr);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        resp_ready = rr;
    endtask

    function automatic void modelReset();
        mValid = 0; mId = 0; mResult = '0; mBusy = 0; mLastWinner = 1;
    endfunction

    task automatic doReset();
        applyStimulus(0, 2'd0, '0, '0, 0, 2'd0, '0, '0, 1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        modelReset();
    endtask

    // One clock: check readys against the model's expected winner, advance the
    // model, then check the registered response after the edge.
    task automatic runCycle(output int winner);
        bit slotFree;
        bit stalled;
        #2;
        slotFree = !mValid || resp_ready;
        stalled  = mValid && !resp_ready;
        winner   = -1;
        if (slotFree) begin
            if (req0_valid && req1_valid) winner = (mLastWinner == 0) ? 1 : 0;
            else if (req0_valid)          winner = 0;
            else if (req1_valid)          winner = 1;
        end
        checkOutput("req0_ready", 64'(req0_ready), 64'(winner == 0));
        checkOutput("req1_ready", 64'(req1_ready), 64'(winner == 1));
        if (winner >= 0) begin
            mResult     = (winner == 0) ? refOp(req0_op, req0_a, req0_b)
                                        : refOp(req1_op, req1_a, req1_b);
            mId         = winner;
            mValid      = 1;
            mLastWinner = winner;
        end else if (mValid && resp_ready) begin
            mValid = 0;
        end
        if (stalled && mBusy < 65535) mBusy++;
        @(posedge clk);
        #1;
        checkOutput("resp_valid", 64'(resp_valid), 64'(mValid));
        if (mValid) begin
            checkOutput("resp_id", 64'(resp_id), 64'(mId));
            checkOutput("resp_result", resp_result, mResult);
        end
        checkOutput("busy_cycles", 64'(busy_cycles), 64'(mBusy));
    endtask

    initial begin
        int win;
        int pend0, pend1;
        logic [1:0]  ops0 [4];
        logic [1:0]  ops1 [4];
        logic [63:0] r0a, r0b, r1a, r1b;
        logic [1:0]  r0op, r1op;
        int k0, k1, n;

        testsRun = 0;
        testsFailed = 0;
        reset = 1'b0;
        doReset();

        checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset_resp_id", 64'(resp_id), 64'd0);
        checkOutput("reset_resp_result", resp_result, 64'd0);
        checkOutput("reset_busy", 64'(busy_cycles), 64'd0);

        // Single AND from requester 0
        applyStimulus(1, 2'd0, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F,
                      0, 2'd0, '0, '0, 1);
        runCycle(win);
        checkOutput("first_winner", 64'(win), 64'd0);
        checkOutput("and_result", resp_result, 64'h0F0F_0000_0F0F_0000);
        applyStimulus(0, 2'd0, '0, '0, 0, 2'd0, '0, '0, 1);
        runCycle(win);

        // Both valid from reset: strict alternation starting with requester 0
        doReset();
        ops0 = '{2'd0, 2'd1, 2'd2, 2'd3};
        ops1 = '{2'd3, 2'd2, 2'd1, 2'd0};
        k0 = 0; k1 = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, ops0[k0 % 4], 64'hDEAD_BEEF_0000_0000 + 64'(k0),
                          64'h1234_5678_9ABC_DEF0, 1, ops1[k1 % 4],
                          64'h0F0F_F0F0_AAAA_5555 + 64'(k1), 64'hFFFF_0000_1111_2222, 1);
            runCycle(win);
            checkOutput("alternate_winner", 64'(win), 64'(i % 2));
            if (win == 0) k0++;
            else if (win == 1) k1++;
        end
        applyStimulus(0, 2'd0, '0, '0, 0, 2'd0, '0, '0, 1);
        runCycle(win);

        // ANDN from requester 1 followed by 5 cycles of backpressure
        doReset();
        applyStimulus(0, 2'd0, '0, '0, 1, 2'd3, 64'hFF, 64'h0F, 1);
        runCycle(win);
        applyStimulus(1, 2'd1, 64'h3, 64'h4, 1, 2'd0, 64'h7, 64'h7, 0);
        for (int i = 0; i < 5; i++) runCycle(win);
        checkOutput("stall_result", resp_result, 64'hF0);
        checkOutput("stall_busy", 64'(busy_cycles), 64'd5);
        applyStimulus(0, 2'd0, '0, '0, 0, 2'd0, '0, '0, 1);
        runCycle(win);
        checkOutput("drained", 64'(resp_valid), 64'd0);
        applyStimulus(1, 2'd1, 64'h3, 64'h4, 1, 2'd0, 64'h7, 64'h7, 1);
        runCycle(win);
        checkOutput("after_drain_winner", 64'(win), 64'd0);

        // Requester 0 wins, then an idle gap, then a tie goes to requester 1
        applyStimulus(1, 2'd2, 64'hAA, 64'h55, 0, 2'd0, '0, '0, 1);
        runCycle(win);
        applyStimulus(0, 2'd0, '0, '0, 0, 2'd0, '0, '0, 1);
        runCycle(win);
        runCycle(win);
        applyStimulus(1, 2'd2, 64'hAA, 64'h55, 1, 2'd1, 64'hF000, 64'h000F, 1);
        runCycle(win);
        checkOutput("tie_after_idle", 64'(win), 64'd1);

        // Random traffic; a requester holds its operation until it is accepted
        pend0 = 0; pend1 = 0;
        r0op = '0; r0a = '0; r0b = '0; r1op = '0; r1a = '0; r1b = '0;
        for (int i = 0; i < 300; i++) begin
            if (pend0 == 0 && $urandom_range(9) < 6) begin
                pend0 = 1; r0op = 2'($urandom_range(3));
                r0a = {$urandom, $urandom}; r0b = {$urandom, $urandom};
            end
            if (pend1 == 0 && $urandom_range(9) < 6) begin
                pend1 = 1; r1op = 2'($urandom_range(3));
                r1a = {$urandom, $urandom}; r1b = {$urandom, $urandom};
            end
            applyStimulus(pend0 != 0, r0op, r0a, r0b, pend1 != 0, r1op, r1a, r1b,
                          $urandom_range(9) < 7);
            runCycle(win);
            if (win == 0) pend0 = 0;
            else if (win == 1) pend1 = 0;
        end

        // Saturation of the stall counter
        applyStimulus(1, 2'd1, 64'h1, 64'h2, 0, 2'd0, '0, '0, 1);
        runCycle(win);
        applyStimulus(0, 2'd0, '0, '0, 0, 2'd0, '0, '0, 0);
        n = 65534 - mBusy;
        repeat (n) @(posedge clk);
        #1;
        mBusy = 65534;
        checkOutput("busy_fffe", 64'(busy_cycles), 64'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("busy_saturated", 64'(busy_cycles), 64'hFFFF);
        checkOutput("stall_valid_held", 64'(resp_valid), 64'd1);
        checkOutput("stall_result_held", resp_result, 64'h3);

        // Asynchronous reset mid-operation
        applyStimulus(1, 2'd0, 64'hF, 64'h3, 1, 2'd2, 64'hF, 64'h3, 0);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("async_busy", 64'(busy_cycles), 64'd0);
        checkOutput("async_result", resp_result, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        modelReset();
        resp_ready = 1'b1;
        runCycle(win);
        checkOutput("post_reset_tie", 64'(win), 64'd0);
        runCycle(win);
        checkOutput("post_reset_second", 64'(win), 64'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
